ppu_video_timing: RTL and testbench
===================================

# ppu_video_timing

Parametrised raster timing generator for the PPU core. It derives the pixel-clock enable from the master clock and runs the H/V dot counters. It decodes picture, blanking, sync and burst windows, and owns the VBlank flag and the /INT output. It generalises the fixed NTSC H/V counter, decoder and VBlank logic so that NTSC, PAL and Dendy rasters come from one block. It adds odd-frame dot skipping and a VBlank-read race rule, neither of which the fixed logic has.

## Interface
Parameters:
- PCLK_DIV, 4: master clocks per pixel (NTSC 4, PAL/Dendy 5); legal range 2..15.
- H_TOTAL, 341: dots per line.
- V_TOTAL, 262: lines per frame.
- H_VIS, 256: visible dots per line.
- V_VIS, 240: visible lines.
- VBL_LINE, 241: line on which VBlank sets.
- PRE_LINE, 261: pre-render line, which clears VBlank; must equal V_TOTAL-1.
- HSYNC_BEG, 277 / HSYNC_END, 302: H sync window [BEG,END).
- BURST_BEG, 302 / BURST_END, 320: color burst window [BEG,END).
- VSYNC_BEG, 244 / VSYNC_END, 247: V sync lines [BEG,END).
- ODD_SKIP, 1: enables dropping one dot on odd frames.

Ports:
- CLK in 1: master clock; the single clock. All state updates on the rising edge.
- n_RES in 1: asynchronous active-low reset.
- BLACK in 1: rendering disabled ($2001[3]=$2001[4]=0).
- VBL_EN in 1: $2000[7], the VBlank interrupt enable.
- R2_RD in 1: one-CLK pulse, CPU read of $2002.
- PCLK_EN out 1: one-CLK pixel enable.
- H out 9: dot counter.
- V out 9: line counter.
- ODD out 1: frame parity.
- VBL_FLAG out 1: $2002[7].
- n_INT out 1: interrupt, active-low, registered.
- n_PICTURE out 1: low inside the visible area.
- BLNK out 1: rendering blanked.
- SYNC out 1: sync pulse.
- BURST out 1: burst window.
- RESCL out 1: VBlank-clear event.
- FRAME_START out 1: one-CLK pulse at (0,0).

## Operation
- Prescaler P counts 0..PCLK_DIV-1 and wraps. PCLK_EN = (P == PCLK_DIV-1), decoded from P.
- On a CLK edge with PCLK_EN=1, the next H/V are computed as follows:
  - Skip condition: ODD_SKIP=1, ODD=1, BLACK=0, V=PRE_LINE, H=H_TOTAL-2. When it holds: H←0, V←0, ODD←0. The dot H_TOTAL-1 is dropped.
  - Else if H=H_TOTAL-1: H←0.
    - If V=V_TOTAL-1: V←0 and ODD toggles.
    - Otherwise V←V+1.
  - Else H←H+1.
- H and V are unsigned; with legal parameters they never exceed H_TOTAL-1 / V_TOTAL-1.
- VBL_FLAG:
  - Set on the PCLK_EN edge where (V,H)=(VBL_LINE,1).
  - Cleared on the PCLK_EN edge where (V,H)=(PRE_LINE,1).
  - Cleared on any CLK edge with R2_RD=1.
  - If a set and R2_RD coincide on the same edge, the flag stays 0 for the whole frame (race suppression). The read returns the old value, 0.
  - Clear has priority over set. With legal parameters the two cannot coincide.
- n_INT is registered each CLK as !(VBL_FLAG & VBL_EN). VBL_EN rising while the flag is set asserts n_INT on the next edge.
- Combinational decodes from the registered P, H, V:
  - n_PICTURE = !(V<V_VIS & H<H_VIS).
  - BLNK = BLACK | (V>=V_VIS & V!=PRE_LINE).
  - SYNC = H in the HSYNC window, or V in the VSYNC window.
  - BURST = H in the BURST window & V outside the VSYNC window.
  - RESCL = (V=PRE_LINE & H=1 & PCLK_EN).
  - FRAME_START = (V=0 & H=0 & PCLK_EN).

## Timing
- Reset values: P=0, H=0, V=0, ODD=0, VBL_FLAG=0, n_INT=1, PCLK_EN=0. Decodes follow from these, e.g. n_PICTURE=0, FRAME_START=0.
- Reset asserted mid-frame forces all state to the reset values immediately. Counting resumes on the first edge after release. The first PCLK_EN comes PCLK_DIV-1 edges after release.
- H/V advance on the edge where PCLK_EN=1. The new value is visible for the next PCLK_DIV CLKs.
- VBL_FLAG changes on the qualifying edge. n_INT follows one CLK later.
- BLACK is sampled on the skip-decision edge only. Toggling it elsewhere has no effect on the skip.
- Frame length in dots:
  - Even frame: H_TOTAL*V_TOTAL.
  - Odd frame with rendering on and ODD_SKIP=1: one dot less.

## Test plan
- Reset release with defaults → PCLK_EN high on the 4th CLK edge after release. H reads 1 after that edge. H wraps 340→0 with V 0→1 after 341 PCLK_EN pulses.
- Two frames with defaults, BLACK=0 → frame 0 (ODD=0) has 89342 PCLK_EN pulses, frame 1 (ODD=1) has 89341; FRAME_START spacing matches. Repeat with BLACK=1 → both frames have 89342.
- PAL set (PCLK_DIV=5, V_TOTAL=312, VBL_LINE=241, PRE_LINE=311, ODD_SKIP=0) → every frame has 106392 dots. Consecutive FRAME_START pulses are 531960 CLKs apart.
- VBL_EN=1 → VBL_FLAG rises at (241,1) and n_INT falls one CLK later. R2_RD pulse → flag 0 and n_INT=1 on the following CLK. RESCL pulses at (261,1).
- R2_RD on the exact set edge → VBL_FLAG stays 0 and n_INT stays 1 through line 261.
- n_RES pulsed low at (100,200) → H=V=0, VBL_FLAG=0, n_INT=1 during reset. After release, the frame restarts with ODD=0.

Source files
------------

// File: rtl/ppu_video_timing.sv
// ============================================================================
// ppu_video_timing : pixel enable, H/V dot counters, raster decodes, VBlank/INT
// Rev 1.0
// ============================================================================
`default_nettype none

module ppu_video_timing #(
  parameter int PCLK_DIV  = 4,
  parameter int H_TOTAL   = 341,
  parameter int V_TOTAL   = 262,
  parameter int H_VIS     = 256,
  parameter int V_VIS     = 240,
  parameter int VBL_LINE  = 241,
  parameter int PRE_LINE  = 261,
  parameter int HSYNC_BEG = 277,
  parameter int HSYNC_END = 302,
  parameter int BURST_BEG = 302,
  parameter int BURST_END = 320,
  parameter int VSYNC_BEG = 244,
  parameter int VSYNC_END = 247,
  parameter int ODD_SKIP  = 1
) (
  input  logic       CLK,
  input  logic       n_RES,
  input  logic       BLACK,
  input  logic       VBL_EN,
  input  logic       R2_RD,
  output logic       PCLK_EN,
  output logic [8:0] H,
  output logic [8:0] V,
  output logic       ODD,
  output logic       VBL_FLAG,
  output logic       n_INT,
  output logic       n_PICTURE,
  output logic       BLNK,
  output logic       SYNC,
  output logic       BURST,
  output logic       RESCL,
  output logic       FRAME_START
);

  localparam logic [3:0] P_LAST   = 4'(PCLK_DIV - 1);
  localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_SKIP   = 9'(H_TOTAL - 2);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_VIS_C  = 9'(H_VIS);
  localparam logic [8:0] V_VIS_C  = 9'(V_VIS);
  localparam logic [8:0] VBL_C    = 9'(VBL_LINE);
  localparam logic [8:0] PRE_C    = 9'(PRE_LINE);
  localparam logic [8:0] HS_BEG_C = 9'(HSYNC_BEG);
  localparam logic [8:0] HS_END_C = 9'(HSYNC_END);
  localparam logic [8:0] BU_BEG_C = 9'(BURST_BEG);
  localparam logic [8:0] BU_END_C = 9'(BURST_END);
  localparam logic [8:0] VS_BEG_C = 9'(VSYNC_BEG);
  localparam logic [8:0] VS_END_C = 9'(VSYNC_END);
  localparam logic       SKIP_EN  = (ODD_SKIP != 0);

  logic [3:0] p;
  logic       skip;
  logic       vbl_set;
  logic       vbl_clr;
  logic       h_sync_win;
  logic       v_sync_win;
  logic       burst_win;

  // Prescaler: PCLK_EN is a pure decode of the count, so it is low in reset.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      p <= 4'd0;
    end else if (PCLK_EN) begin
      p <= 4'd0;
    end else begin
      p <= p + 4'd1;
    end
  end

  assign PCLK_EN = (p == P_LAST);

  // Odd frames with rendering on jump from the pre-render line straight to (0,0).
  assign skip = SKIP_EN && ODD && !BLACK && (V == PRE_C) && (H == H_SKIP);

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      H   <= 9'd0;
      V   <= 9'd0;
      ODD <= 1'b0;
    end else if (PCLK_EN) begin
      if (skip) begin
        H   <= 9'd0;
        V   <= 9'd0;
        ODD <= 1'b0;
      end else if (H == H_LAST) begin
        H <= 9'd0;
        if (V == V_LAST) begin
          V   <= 9'd0;
          ODD <= ~ODD;
        end else begin
          V <= V + 9'd1;
        end
      end else begin
        H <= H + 9'd1;
      end
    end
  end

  assign vbl_set = PCLK_EN && (V == VBL_C) && (H == 9'd1);
  assign vbl_clr = PCLK_EN && (V == PRE_C) && (H == 9'd1);

  // A $2002 read landing on the set edge wins, so the flag never shows that frame.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      VBL_FLAG <= 1'b0;
      n_INT    <= 1'b1;
    end else begin
      if (R2_RD || vbl_clr) begin
        VBL_FLAG <= 1'b0;
      end else if (vbl_set) begin
        VBL_FLAG <= 1'b1;
      end
      n_INT <= !(VBL_FLAG && VBL_EN);
    end
  end

  assign h_sync_win = (H >= HS_BEG_C) && (H < HS_END_C);
  assign v_sync_win = (V >= VS_BEG_C) && (V < VS_END_C);
  assign burst_win  = (H >= BU_BEG_C) && (H < BU_END_C);

  assign n_PICTURE   = !((V < V_VIS_C) && (H < H_VIS_C));
  assign BLNK        = BLACK || ((V >= V_VIS_C) && (V != PRE_C));
  assign SYNC        = h_sync_win || v_sync_win;
  assign BURST       = burst_win && !v_sync_win;
  assign RESCL       = vbl_clr;
  assign FRAME_START = PCLK_EN && (V == 9'd0) && (H == 9'd0);

endmodule

`default_nettype wire

// File: tb/tb_ppu_video_timing.sv
// ============================================================================
// tb_ppu_video_timing : directed checks of a reduced NTSC-style and PAL-style raster
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ppu_video_timing;

  logic       CLK = 1'b0;
  logic       n_RES = 1'b0;
  logic       BLACK = 1'b0;
  logic       VBL_EN = 1'b0;
  logic       R2_RD = 1'b0;
  logic       PCLK_EN;
  logic [8:0] H;
  logic [8:0] V;
  logic       ODD, VBL_FLAG, n_INT, n_PICTURE, BLNK, SYNC, BURST, RESCL, FRAME_START;

  logic       pal_pclk_en;
  logic [8:0] pal_h;
  logic [8:0] pal_v;
  logic       pal_odd, pal_vbl, pal_n_int, pal_n_pic, pal_blnk, pal_sync, pal_burst, pal_rescl, pal_fs;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fs_q[$];
  int pal_q[$];

  // 20 dots x 12 lines, 4 CLK per dot: 960 CLK per full frame
  ppu_video_timing #(
    .PCLK_DIV(4), .H_TOTAL(20), .V_TOTAL(12), .H_VIS(16), .V_VIS(8),
    .VBL_LINE(9), .PRE_LINE(11), .HSYNC_BEG(17), .HSYNC_END(18),
    .BURST_BEG(18), .BURST_END(19), .VSYNC_BEG(9), .VSYNC_END(10), .ODD_SKIP(1)
  ) u_dut (
    .CLK(CLK), .n_RES(n_RES), .BLACK(BLACK), .VBL_EN(VBL_EN), .R2_RD(R2_RD),
    .PCLK_EN(PCLK_EN), .H(H), .V(V), .ODD(ODD), .VBL_FLAG(VBL_FLAG), .n_INT(n_INT),
    .n_PICTURE(n_PICTURE), .BLNK(BLNK), .SYNC(SYNC), .BURST(BURST), .RESCL(RESCL),
    .FRAME_START(FRAME_START)
  );

  // PAL-style: 20 dots x 14 lines, 5 CLK per dot, no skip: 1400 CLK per frame
  ppu_video_timing #(
    .PCLK_DIV(5), .H_TOTAL(20), .V_TOTAL(14), .H_VIS(16), .V_VIS(8),
    .VBL_LINE(9), .PRE_LINE(13), .HSYNC_BEG(17), .HSYNC_END(18),
    .BURST_BEG(18), .BURST_END(19), .VSYNC_BEG(9), .VSYNC_END(10), .ODD_SKIP(0)
  ) u_pal (
    .CLK(CLK), .n_RES(n_RES), .BLACK(1'b0), .VBL_EN(1'b0), .R2_RD(1'b0),
    .PCLK_EN(pal_pclk_en), .H(pal_h), .V(pal_v), .ODD(pal_odd), .VBL_FLAG(pal_vbl),
    .n_INT(pal_n_int), .n_PICTURE(pal_n_pic), .BLNK(pal_blnk), .SYNC(pal_sync),
    .BURST(pal_burst), .RESCL(pal_rescl), .FRAME_START(pal_fs)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (FRAME_START) fs_q.push_back(cyc);
    if (pal_fs) pal_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: timeout at V=%0d H=%0d", tag, V, H);
  endtask

  task automatic go(input int v, input int h);
    int n = 0;
    while (!(32'(V) == v && 32'(H) == h) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) timeout("goto");
  endtask

  task automatic wait_fs(input int count);
    int n = 0;
    while (fs_q.size() < count && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) timeout("wait_frame_start");
  endtask

  initial begin
    int cnt;
    logic seen_flag;
    logic seen_int;

    repeat (3) tick();
    chk("rst_H", 32'(H), 0);
    chk("rst_V", 32'(V), 0);
    chk("rst_ODD", 32'(ODD), 0);
    chk("rst_VBL_FLAG", 32'(VBL_FLAG), 0);
    chk("rst_n_INT", 32'(n_INT), 1);
    chk("rst_PCLK_EN", 32'(PCLK_EN), 0);
    chk("rst_n_PICTURE", 32'(n_PICTURE), 0);
    chk("rst_FRAME_START", 32'(FRAME_START), 0);

    // release; PCLK_EN sampled high on the 4th edge
    n_RES = 1'b1;
    tick(); tick();
    chk("pclk_en_early", 32'(PCLK_EN), 0);
    tick();
    chk("pclk_en_first", 32'(PCLK_EN), 1);
    chk("frame_start_first", 32'(FRAME_START), 1);
    tick();
    chk("H_after_first_en", 32'(H), 1);
    chk("pclk_en_after", 32'(PCLK_EN), 0);

    cnt = 4;
    while (!(H == 9'd0 && V == 9'd1) && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("line_wrap_cycles", 32'(cnt), 80);
    chk("picture_at_1_0", 32'(n_PICTURE), 0);
    chk("sync_at_1_0", 32'(SYNC), 0);
    chk("blnk_at_1_0", 32'(BLNK), 0);
    go(1, 17);
    chk("hsync_at_17", 32'(SYNC), 1);
    chk("n_picture_at_17", 32'(n_PICTURE), 1);
    go(1, 18);
    chk("hsync_end_18", 32'(SYNC), 0);
    chk("burst_at_18", 32'(BURST), 1);
    go(1, 19);
    chk("burst_end_19", 32'(BURST), 0);

    // frame 0: VBlank set, interrupt, read-clear
    VBL_EN = 1'b1;
    go(9, 1);
    chk("vbl_before_set", 32'(VBL_FLAG), 0);
    chk("vsync_line9", 32'(SYNC), 1);
    chk("blnk_line9", 32'(BLNK), 1);
    repeat (3) tick();
    chk("pclk_en_at_set", 32'(PCLK_EN), 1);
    tick();
    chk("vbl_set", 32'(VBL_FLAG), 1);
    chk("n_int_lag", 32'(n_INT), 1);
    chk("H_after_set", 32'(H), 2);
    tick();
    chk("n_int_assert", 32'(n_INT), 0);
    go(9, 18);
    chk("burst_masked_vsync", 32'(BURST), 0);
    R2_RD = 1'b1;
    tick();
    R2_RD = 1'b0;
    chk("vbl_read_clear", 32'(VBL_FLAG), 0);
    chk("n_int_still_low", 32'(n_INT), 0);
    tick();
    chk("n_int_release", 32'(n_INT), 1);
    go(11, 1);
    chk("blnk_pre_line", 32'(BLNK), 0);
    chk("rescl_p0", 32'(RESCL), 0);
    repeat (3) tick();
    chk("rescl_pulse", 32'(RESCL), 1);
    tick();

    // frame 1 (odd): BLACK toggled mid-frame, read race at set edge, skip
    go(0, 0);
    chk("odd_frame1", 32'(ODD), 1);
    go(2, 5);
    BLACK = 1'b1;
    tick();
    chk("blnk_black", 32'(BLNK), 1);
    go(4, 5);
    BLACK = 1'b0;
    tick();
    chk("blnk_unblack", 32'(BLNK), 0);
    go(9, 1);
    repeat (3) tick();
    R2_RD = 1'b1;
    tick();
    R2_RD = 1'b0;
    chk("race_flag", 32'(VBL_FLAG), 0);
    seen_flag = 1'b0;
    seen_int  = 1'b0;
    cnt = 0;
    while (!(V == 9'd11 && H == 9'd2) && cnt < 2000) begin
      seen_flag = seen_flag | VBL_FLAG;
      seen_int  = seen_int | !n_INT;
      tick();
      cnt++;
    end
    if (cnt >= 2000) timeout("race_window");
    chk("race_flag_never", 32'(seen_flag), 0);
    chk("race_int_never", 32'(seen_int), 0);
    go(11, 18);
    chk("odd_before_skip", 32'(ODD), 1);
    repeat (3) tick();
    chk("pclk_en_skip", 32'(PCLK_EN), 1);
    tick();
    chk("skip_H", 32'(H), 0);
    chk("skip_V", 32'(V), 0);
    chk("skip_ODD", 32'(ODD), 0);

    // frame 2 (even): VBL_EN gating, RESCL clear
    go(10, 3);
    chk("vbl_frame2", 32'(VBL_FLAG), 1);
    chk("n_int_frame2", 32'(n_INT), 0);
    VBL_EN = 1'b0;
    tick();
    chk("n_int_en_off", 32'(n_INT), 1);
    VBL_EN = 1'b1;
    tick();
    chk("n_int_en_on", 32'(n_INT), 0);
    go(11, 1);
    chk("vbl_before_rescl", 32'(VBL_FLAG), 1);
    repeat (3) tick();
    chk("rescl_frame2", 32'(RESCL), 1);
    tick();
    chk("vbl_rescl_clear", 32'(VBL_FLAG), 0);
    tick();
    chk("n_int_rescl", 32'(n_INT), 1);
    BLACK = 1'b1;

    // frame 3 (odd) with rendering off: no skip
    go(0, 0);
    chk("odd_frame3", 32'(ODD), 1);
    chk("blnk_black_top", 32'(BLNK), 1);
    wait_fs(5);
    BLACK = 1'b0;
    if (fs_q.size() >= 5) begin
      chk("frame0_len", 32'(fs_q[1] - fs_q[0]), 960);
      chk("frame1_len_skip", 32'(fs_q[2] - fs_q[1]), 956);
      chk("frame2_len", 32'(fs_q[3] - fs_q[2]), 960);
      chk("frame3_len_black", 32'(fs_q[4] - fs_q[3]), 960);
    end
    chk("pal_frames_seen", 32'(pal_q.size() >= 3), 1);
    if (pal_q.size() >= 3) begin
      chk("pal_frame0_len", 32'(pal_q[1] - pal_q[0]), 1400);
      chk("pal_frame1_len", 32'(pal_q[2] - pal_q[1]), 1400);
    end

    // frame 5 (odd): reset mid-frame with VBlank set
    wait_fs(6);
    chk("odd_frame5", 32'(ODD), 1);
    go(10, 5);
    chk("vbl_before_reset", 32'(VBL_FLAG), 1);
    n_RES = 1'b0;
    #1;
    chk("async_rst_H", 32'(H), 0);
    chk("async_rst_V", 32'(V), 0);
    chk("async_rst_VBL", 32'(VBL_FLAG), 0);
    chk("async_rst_n_INT", 32'(n_INT), 1);
    chk("async_rst_ODD", 32'(ODD), 0);
    tick(); tick();
    chk("held_rst_H", 32'(H), 0);
    n_RES = 1'b1;
    repeat (3) tick();
    chk("restart_frame_start", 32'(FRAME_START), 1);
    chk("restart_ODD", 32'(ODD), 0);
    tick();
    chk("restart_H", 32'(H), 1);
    chk("restart_V", 32'(V), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
